i2s_receiver: RTL

//  I2S receive path, the counterpart of our I2S transmit controller. Takes codec-side bit_clk/frame_clk/data
//  (Philips format, MSB first, 1-bit delay after frame_clk edge) and rebuilds 16-bit stereo sample pairs.
//  Bit/frame clocks are sampled as data in the clk domain; no logic runs on bit_clk itself.

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_sync_edge.sv | 33 +++
 rtl/i2s_receiver.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the transmit controller and the receiver.
package i2s_pkg;

  localparam int unsigned I2S_SAMPLE_WIDTH = 16;

  // Word-select level on the bus.
  typedef enum logic {
    ChLeft  = 1'b0,
    ChRight = 1'b1
  } i2s_chan_e;

  typedef enum logic [1:0] {
    StAlign = 2'd0,
    StRecvL = 2'd1,
    StRecvR = 2'd2
  } i2s_rx_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rising-edge detect on the synced value.
module i2s_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   prev_d, prev_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// Philips-format I2S receiver: oversamples bit_clk/frame_clk/data and rebuilds stereo pairs.
// Define I2S_RX_FRAME_CHECK_EN to build the per-word bit-count check that drives frame_err.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bit_clk,
  input  logic                    frame_clk,
  input  logic                    data,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  output logic                    frame_err
);

  localparam int unsigned CntW = $clog2(SAMPLE_WIDTH + 2);
`ifdef I2S_RX_FRAME_CHECK_EN
  // One extra count lets an over-long word be told apart from an exact one.
  localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_WIDTH + 1);
`else
  localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_WIDTH);
`endif
  localparam logic [SAMPLE_WIDTH-1:0] MsbOne = {1'b1, {(SAMPLE_WIDTH - 1){1'b0}}};

  logic      bc_rise, ws_sync, data_sync;
  logic      ws_rise_unused, data_rise_unused;
  logic      unused_rise;
  i2s_chan_e ws_chan;

  i2s_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_bclk (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (bit_clk),
    .q_o   (),
    .rise_o(bc_rise)
  );

  i2s_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_ws (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (frame_clk),
    .q_o   (ws_sync),
    .rise_o(ws_rise_unused)
  );

  i2s_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_data (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (data),
    .q_o   (data_sync),
    .rise_o(data_rise_unused)
  );

  assign unused_rise = ws_rise_unused ^ data_rise_unused;
  assign ws_chan     = i2s_chan_e'(ws_sync);

  // Serial capture: bits are dropped straight into their left-aligned slot, so
  // short words end up zero-padded and bits past SAMPLE_WIDTH fall off.
  i2s_chan_e                ws_d_d, ws_d_q;
  logic [CntW-1:0]          cnt_d, cnt_q;
  logic [SAMPLE_WIDTH-1:0]  sr_d, sr_q;
  logic [SAMPLE_WIDTH-1:0]  word;
  logic                     word_end;

  always_comb begin
    ws_d_d   = ws_d_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    word_end = 1'b0;
    word     = data_sync ? (sr_q | (MsbOne >> cnt_q)) : sr_q;
    if (bc_rise) begin
      ws_d_d = ws_chan;
      if (ws_chan != ws_d_q) begin
        // The bit on this rise is the LSB of the word that just finished.
        word_end = 1'b1;
        cnt_d    = '0;
        sr_d     = '0;
      end else begin
        sr_d = word;
        if (cnt_q < CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ws_d_q <= ChLeft;
      cnt_q  <= '0;
      sr_q   <= '0;
    end else begin
      ws_d_q <= ws_d_d;
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  logic word_bad;
  logic left_err_d, left_err_q;
  logic frame_err_d, frame_err_q;

  // cnt_q excludes the LSB captured on the word-end rise.
  assign word_bad = (cnt_q != CntW'(SAMPLE_WIDTH - 1));
`endif

  // Pair assembly.
  i2s_rx_state_e            state_d, state_q;
  logic [SAMPLE_WIDTH-1:0]  left_hold_d, left_hold_q;
  logic [SAMPLE_WIDTH-1:0]  sample_left_d, sample_left_q;
  logic [SAMPLE_WIDTH-1:0]  sample_right_d, sample_right_q;
  logic                     sample_valid_d, sample_valid_q;

  always_comb begin
    state_d        = state_q;
    left_hold_d    = left_hold_q;
    sample_left_d  = sample_left_q;
    sample_right_d = sample_right_q;
    sample_valid_d = 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
    left_err_d     = left_err_q;
    frame_err_d    = frame_err_q;
`endif
    if (word_end) begin
      unique case (state_q)
        StAlign: begin
          if (ws_d_q == ChRight) begin
            state_d = StRecvL;
          end
        end
        StRecvL: begin
          if (ws_d_q == ChLeft) begin
            left_hold_d = word;
`ifdef I2S_RX_FRAME_CHECK_EN
            left_err_d  = word_bad;
`endif
            state_d     = StRecvR;
          end else begin
            state_d = StAlign;
          end
        end
        StRecvR: begin
          if (ws_d_q == ChRight) begin
            sample_left_d  = left_hold_q;
            sample_right_d = word;
            sample_valid_d = 1'b1;
`ifdef I2S_RX_FRAME_CHECK_EN
            frame_err_d    = left_err_q | word_bad;
`endif
            state_d        = StRecvL;
          end else begin
            state_d = StAlign;
          end
        end
        default: state_d = StAlign;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StAlign;
      left_hold_q    <= '0;
      sample_left_q  <= '0;
      sample_right_q <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      left_hold_q    <= left_hold_d;
      sample_left_q  <= sample_left_d;
      sample_right_q <= sample_right_d;
      sample_valid_q <= sample_valid_d;
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      left_err_q  <= left_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign sample_left  = sample_left_q;
  assign sample_right = sample_right_q;
  assign sample_valid = sample_valid_q;

endmodule
